// File: rtl/tpic2mem_if.sv
// tpic2mem_if: serial-in pins and latched parallel outputs of the tpic2mem receiver.
interface tpic2mem_if #(parameter int WIDTH = 16);
    logic             sclk_in;
    logic             sin;
    logic             rck_in;
    logic             g_n_in;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             frame_err;
    modport master (output sclk_in, sin, rck_in, g_n_in, input data, data_valid, frame_err);
    modport slave (input sclk_in, sin, rck_in, g_n_in, output data, data_valid, frame_err);
endinterface

// File: rtl/tpic2mem.sv
// tpic2mem: serial shift/latch receiver (TPIC-style) into a gated parallel word.
// Optional frame length check enabled by defining TPIC2MEM_FRAME_CHECK_EN.
module tpic2mem #(parameter int WIDTH = 16) (
    input logic      clk,
    input logic      reset,
    tpic2mem_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;
    state_t           state;
    logic [3:0]       s1, s2, hist;
    logic             sclk_rise, rck_rise;
    logic [WIDTH-1:0] shift_reg, hold_reg;
    // bit order {g_n, rck, sin, sclk}; g_n idles high so the output starts gated
    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 4'b1000;
            s2        <= 4'b1000;
            hist      <= 4'b1000;
            sclk_rise <= 1'b0;
            rck_rise  <= 1'b0;
        end else begin
            s1        <= {bus.g_n_in, bus.rck_in, bus.sin, bus.sclk_in};
            s2        <= s1;
            hist      <= s2;
            sclk_rise <= s2[0] & ~hist[0];
            rck_rise  <= s2[2] & ~hist[2];
        end
    end
    // hist[1] is the sin sample taken alongside the sclk edge just flagged
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
        end else begin
            if (sclk_rise) shift_reg <= {shift_reg[WIDTH-2:0], hist[1]};
            if (rck_rise) hold_reg <= shift_reg;
            state <= rck_rise ? S_LATCH : sclk_rise ? S_SHIFT : (state == S_LATCH) ? S_IDLE : state;
        end
    end
    assign bus.data_valid = (state == S_LATCH);
    assign bus.data       = hist[3] ? '0 : hold_reg;
`ifdef TPIC2MEM_FRAME_CHECK_EN
    logic [5:0] bit_cnt;
    logic       frame_err_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            frame_err_r <= 1'b0;
        end else if (rck_rise) begin
            bit_cnt     <= {5'd0, sclk_rise};
            frame_err_r <= (bit_cnt != 6'(WIDTH));
        end else if (sclk_rise && bit_cnt != 6'd63) begin
            bit_cnt <= bit_cnt + 6'd1;
        end
    end
    assign bus.frame_err = frame_err_r;
`else
    assign bus.frame_err = 1'b0;
`endif
endmodule
